// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults, FSM state and port encodings for the memory arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF   = 6;
   localparam int DATA_W_DEF   = 32;
   localparam int WP_LIMIT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic {
      PORT_A,
      PORT_B
   } port_t;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin pick; contention goes to the port not granted last
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic  a_req,
   input  logic  b_req,
   input  port_t last_grant,
   output port_t winner
);

   always_comb begin
      winner = PORT_A;
      if (a_req && b_req) begin
         winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else if (b_req) begin
         winner = PORT_B;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sharing one synchronous single-port RAM
// Define MEM_ARB_WPROT_EN to reject port-B writes below WP_LIMIT (reported on err).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WP_LIMIT = WP_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   port_t             last_grant;
   port_t             winner;
   port_t             cur;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              blocked;
   logic              blk_q;
   logic              err_q;

   mem_arb_rr u_rr (
      .a_req      (a_req),
      .b_req      (b_req),
      .last_grant (last_grant),
      .winner     (winner)
   );

   assign sel_we    = (winner == PORT_B) ? b_we    : a_we;
   assign sel_addr  = (winner == PORT_B) ? b_addr  : a_addr;
   assign sel_wdata = (winner == PORT_B) ? b_wdata : a_wdata;

`ifdef MEM_ARB_WPROT_EN
   assign blocked = (winner == PORT_B) && b_we && (int'(b_addr) < WP_LIMIT);
`else
   logic unused_wp_limit;
   assign unused_wp_limit = (WP_LIMIT == 0);
   assign blocked         = 1'b0;
`endif

   // RAM read data is registered inside the RAM, so it is already valid in DONE.
   assign rdata = mem_rdata;
   assign err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= PORT_B;
         cur        <= PORT_A;
         blk_q      <= 1'b0;
         err_q      <= 1'b0;
         a_ack      <= 1'b0;
         b_ack      <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               a_ack <= 1'b0;
               b_ack <= 1'b0;
               err_q <= 1'b0;
               if (a_req || b_req) begin
                  cur        <= winner;
                  last_grant <= winner;
                  blk_q      <= blocked;
                  // Captured here so later input changes cannot reach the RAM.
                  mem_read   <= !sel_we;
                  mem_write  <= sel_we && !blocked;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               a_ack     <= (cur == PORT_A);
               b_ack     <= (cur == PORT_B);
               err_q     <= blk_q;
               state     <= DONE;
            end
            DONE: begin
               a_ack <= 1'b0;
               b_ack <= 1'b0;
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a word-array reference model
module tb_mem_arbiter;

   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int WPL = 16;
`ifdef MEM_ARB_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ack, b_ack, err, mem_read, mem_write;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] ram [64];
   logic [DW-1:0] ram_q = '0;
   logic [DW-1:0] ref_mem [64];
   bit            last_b;
   int            n_asserts = 0;
   int            n_fails   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WP_LIMIT(WPL)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack),
      .rdata     (rdata),
      .err       (err),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_read)  ram_q <= ram[mem_addr];
   end
   assign mem_rdata = ram_q;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("rd_wr_exclusive", mem_read & mem_write, '0);
         check("ack_exclusive", a_ack & b_ack, '0);
      end
   end

   function automatic bit is_blocked(input bit port, input bit we, input int addr);
      return WPROT && port && we && (addr < WPL);
   endfunction

   task automatic drive(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (!port) begin
         a_we = we; a_addr = addr; a_wdata = data;
      end else begin
         b_we = we; b_addr = addr; b_wdata = data;
      end
   endtask

   task automatic finish_check(input bit port, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input bit blk);
      check("ack_winner", port ? b_ack : a_ack, 1);
      check("ack_other", port ? a_ack : b_ack, 0);
      check("err", err, DW'(blk));
      if (!we) check("rdata", rdata, ref_mem[addr]);
      else if (!blk) ref_mem[addr] = data;
      last_b = port;
   endtask

   task automatic run_txn(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bit blk;
      blk = is_blocked(port, we, int'(addr));
      drive(port, we, addr, data);
      if (!port) a_req = 1'b1; else b_req = 1'b1;
      @(posedge clk); #1;
      check("access_read", mem_read, DW'(!we));
      check("access_write", mem_write, DW'(we && !blk));
      check("access_addr", mem_addr, addr);
      if (we && !blk) check("access_wdata", mem_wdata, data);
      drive(port, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      @(posedge clk); #1;
      finish_check(port, we, addr, data, blk);
      if (!port) a_req = 1'b0; else b_req = 1'b0;
      @(posedge clk); #1;
      check("idle_a_ack", a_ack, 0);
      check("idle_b_ack", b_ack, 0);
   endtask

   task automatic run_pair(input int n);
      bit            pw [2];
      logic [AW-1:0] pa [2];
      logic [DW-1:0] pd [2];
      bit            w, blk, we0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      for (int p = 0; p < 2; p++) begin
         pw[p] = 1'($urandom_range(0, 1));
         pa[p] = AW'($urandom_range(0, 7));
         pd[p] = DW'($urandom);
         drive(1'(p), pw[p], pa[p], pd[p]);
      end
      a_req = 1'b1;
      b_req = 1'b1;
      for (int k = 0; k < n; k++) begin
         w   = last_b ? 1'b0 : 1'b1;
         blk = is_blocked(w, pw[w], int'(pa[w]));
         we0 = pw[w]; a0 = pa[w]; d0 = pd[w];
         @(posedge clk); #1;
         check("pair_addr", mem_addr, a0);
         check("pair_read", mem_read, DW'(!we0));
         check("pair_write", mem_write, DW'(we0 && !blk));
         pw[w] = 1'($urandom_range(0, 1));
         pa[w] = AW'($urandom_range(0, 7));
         pd[w] = DW'($urandom);
         drive(w, pw[w], pa[w], pd[w]);
         @(posedge clk); #1;
         finish_check(w, we0, a0, d0, blk);
         @(posedge clk); #1;
         check("pair_idle_acks", {a_ack, b_ack}, 0);
      end
      a_req = 1'b0;
      b_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DW-1:0] d;
      for (int i = 0; i < 64; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_ack", a_ack, 0);
      check("rst_b_ack", b_ack, 0);
      check("rst_err", err, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst    = 1'b0;
      last_b = 1'b1;

      run_pair(8);

      run_txn(1'b0, 1'b1, 6'd5, 32'h1234_5678);
      run_txn(1'b0, 1'b0, 6'd5, 32'h0);
      run_txn(1'b1, 1'b1, 6'd63, 32'hDEAD_BEEF);
      run_txn(1'b0, 1'b0, 6'd63, 32'h0);
      run_txn(1'b0, 1'b0, 6'd0, 32'h0);

      run_txn(1'b0, 1'b1, 6'd3, 32'hA5A5_0003);
      run_txn(1'b1, 1'b1, 6'd3, 32'hFFFF_FFFF);
      run_txn(1'b0, 1'b0, 6'd3, 32'h0);
      run_txn(1'b1, 1'b1, 6'd16, 32'h0000_600D);
      run_txn(1'b0, 1'b0, 6'd16, 32'h0);

      drive(1'b0, 1'b0, 6'd5, 32'h0);
      a_req = 1'b1;
      @(posedge clk); #1;
      check("abort_access_read", mem_read, 1);
      rst   = 1'b1;
      a_req = 1'b0;
      @(posedge clk); #1;
      check("abort_a_ack", a_ack, 0);
      check("abort_mem_read", mem_read, 0);
      check("abort_mem_addr", mem_addr, 0);
      rst    = 1'b0;
      last_b = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_no_late_ack", a_ack, 0);
      end
      run_txn(1'b0, 1'b0, 6'd5, 32'h0);

      d = DW'($urandom);
      drive(1'b0, 1'b1, 6'd9, d);
      a_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("done_rst_ack_visible", a_ack, 1);
      rst   = 1'b1;
      a_req = 1'b0;
      @(posedge clk); #1;
      check("done_rst_ack_cleared", a_ack, 0);
      rst        = 1'b0;
      ref_mem[9] = d;
      last_b     = 1'b1;
      run_txn(1'b0, 1'b0, 6'd9, 32'h0);

      for (int i = 0; i < 16; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(56, 63)),
                 DW'($urandom));
      end
      run_pair(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, RAM word address width; DATA_W, default 32, RAM word width; WP_LIMIT, default 16, write-protect bound for port B (used only under REQ-027).
REQ-002 SHALL have ports, one per line:
 clk  in  1  single clock, all state on rising edge
 rst  in  1  reset, synchronous, active-high
 a_req  in  1  port A request, held until a_ack
 a_we  in  1  port A write (1) / read (0)
 a_addr  in  ADDR_W  port A word address
 a_wdata  in  DATA_W  port A write data
 a_ack  out  1  port A transaction complete, one-cycle pulse
 b_req, b_we, b_addr, b_wdata, b_ack  same as port A, for port B
 rdata  out  DATA_W  read data, valid while a_ack or b_ack high
 err  out  1  rejected transaction, valid with ack (REQ-027)
 mem_read  out  1  RAM read enable
 mem_write  out  1  RAM write enable
 mem_addr  out  ADDR_W  RAM address
 mem_wdata  out  DATA_W  RAM write data
 mem_rdata  in  DATA_W  RAM registered read data

Function
REQ-003 SHALL share one single-port synchronous RAM (write and registered read on rising edge, 1-cycle read latency) between ports A and B.
REQ-004 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions except reset.
REQ-005 IDLE: if any req high at the edge, SHALL pick a winner, capture its we/addr/wdata into registers, go to ACCESS; otherwise stay.
REQ-006 Arbitration SHALL be round-robin: one requester -> it wins; both -> the port not granted last wins; last-grant pointer updates on each grant.
REQ-007 ACCESS: mem_write = captured we, mem_read = not captured we, mem_addr/mem_wdata = captured values; exactly one cycle.
REQ-008 mem_read and mem_write SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-009 DONE: winner's ack SHALL be 1 for exactly this cycle; rdata SHALL equal mem_rdata combinationally; for writes rdata is don't-care.
REQ-010 Latency SHALL be fixed: req sampled at edge N, RAM operation at edge N+1, ack high in the cycle after edge N+1, new grant possible at edge N+3 earliest.
REQ-011 Requester SHALL drop req at the edge sampling its ack; a req still high in IDLE after ack is a new transaction.
REQ-012 Changes to winner's we/addr/wdata after grant SHALL be ignored; loser's inputs SHALL be ignored until its grant.
REQ-013 A req withdrawn while in IDLE before being granted SHALL produce no transaction.
REQ-014 The non-winning ack SHALL stay 0 in every state.

Reset
REQ-020 While rst is high at an edge: state -> IDLE, a_ack = b_ack = err = 0, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, last-grant pointer = B (so A wins first contention).
REQ-021 Reset asserted during ACCESS SHALL abort; the RAM may still complete the operation at that same edge (RAM has no reset); no ack SHALL be issued for the aborted transaction.
REQ-022 Reset asserted during DONE SHALL suppress nothing already visible in that cycle, and SHALL clear ack from the following cycle.

Configuration
REQ-027 With MEM_ARB_WPROT_EN defined: a port-B write with addr < WP_LIMIT SHALL still take IDLE->ACCESS->DONE, but mem_write SHALL stay 0 in ACCESS, and b_ack and err SHALL both be 1 in DONE; all other transactions give err = 0.
REQ-028 Without MEM_ARB_WPROT_EN: err SHALL be tied 0, WP_LIMIT unused, all writes performed.

Structure
REQ-030 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, WP_LIMIT default and the FSM state enum (IDLE, ACCESS, DONE).
REQ-031 Round-robin pick SHALL be a sub-module mem_arb_rr (inputs: two reqs, last-grant pointer; output: winner); all else in mem_arbiter.

Verification
REQ-040 A-only write addr 5 data 0x1234_5678, then A read addr 5 -> ack 3 cycles after each req; rdata = 0x1234_5678 in ack cycle.
REQ-041 A and B req in the same cycle after reset -> A granted first, B next; alternation A,B,A,B under continuous requests from both.
REQ-042 B writes 0xDEAD_BEEF to addr 63, A reads addr 63 -> 0xDEAD_BEEF; address wrap 63 is legal, no aliasing with addr 0.
REQ-043 rst pulsed during ACCESS of an A read -> no a_ack, mem_read 0 next cycle, next A req serviced normally.
REQ-044 With MEM_ARB_WPROT_EN: B write addr 3 data 0xFFFF_FFFF -> b_ack = err = 1, mem_write never high, A read addr 3 returns prior value; B write addr 16 succeeds with err = 0.
REQ-045 Winner changes addr/wdata during ACCESS -> RAM sees captured values only; mem_read & mem_write never both 1 (assertion throughout).
